// File: rtl/register_file_pkg.sv
// Shared widths for the architectural register file and its rename table.
package register_file_pkg;
    localparam int unsigned ROB_WIDTH_BIT = 4;
    localparam int unsigned REG_ID_BIT    = 5;
    localparam int unsigned REG_NUM       = 32;
    localparam int unsigned DATA_BIT      = 32;

    // Register 0 is hard-wired zero, so an id of 0 means "no register".
    function automatic logic is_live_reg(input logic [REG_ID_BIT-1:0] id);
        return id != '0;
    endfunction
endpackage

// File: rtl/register_file_operand_resolve.sv
// Picks one source operand: zero reg, stored value, same-cycle commit, ROB forward, or tag.
module reg_operand_resolve
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = ROB_WIDTH_BIT
) (
    input  logic [REG_ID_BIT-1:0]   reg_id,
    input  logic [DATA_BIT-1:0]     reg_val,
    input  logic                    has_dep,
    input  logic [ROB_SIZE_BIT-1:0] dep,
    input  logic                    commit_valid,
    input  logic [REG_ID_BIT-1:0]   commit_reg_id,
    input  logic [ROB_SIZE_BIT-1:0] commit_rob_id,
    input  logic [DATA_BIT-1:0]     commit_val,
    input  logic                    rob_ready,
    input  logic [DATA_BIT-1:0]     rob_value,
    output logic [DATA_BIT-1:0]     val,
    output logic                    pending,
    output logic [ROB_SIZE_BIT-1:0] pending_dep
);
    always_comb begin
        val         = '0;
        pending     = 1'b0;
        pending_dep = '0;
        if (!is_live_reg(reg_id)) begin
            val = '0;
        end else if (!has_dep) begin
            val = reg_val;
        end else if (commit_valid && commit_reg_id == reg_id && commit_rob_id == dep) begin
            val = commit_val;
        end else if (rob_ready) begin
            val = rob_value;
        end else begin
            pending     = 1'b1;
            pending_dep = dep;
        end
    end
endmodule

// File: rtl/register_file.sv
// Architectural registers plus rename table; answers two decoder operand lookups.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = ROB_WIDTH_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic [REG_ID_BIT-1:0]   set_reg_id,
    input  logic [DATA_BIT-1:0]     set_val,
    input  logic [ROB_SIZE_BIT-1:0] set_reg_on_rob_id,
    input  logic [REG_ID_BIT-1:0]   set_dep_reg_id,
    input  logic [ROB_SIZE_BIT-1:0] set_dep_rob_id,
    input  logic [REG_ID_BIT-1:0]   get_reg_1,
    input  logic [REG_ID_BIT-1:0]   get_reg_2,
    output logic [DATA_BIT-1:0]     get_val_1,
    output logic [DATA_BIT-1:0]     get_val_2,
    output logic                    get_has_dep_1,
    output logic                    get_has_dep_2,
    output logic [ROB_SIZE_BIT-1:0] get_dep_1,
    output logic [ROB_SIZE_BIT-1:0] get_dep_2,
    output logic [ROB_SIZE_BIT-1:0] get_rob_id1,
    output logic [ROB_SIZE_BIT-1:0] get_rob_id2,
    input  logic                    rob_value1_ready,
    input  logic [DATA_BIT-1:0]     rob_value1,
    input  logic                    rob_value2_ready,
    input  logic [DATA_BIT-1:0]     rob_value2
);
    logic [DATA_BIT-1:0]     regs    [REG_NUM];
    logic [ROB_SIZE_BIT-1:0] dep     [REG_NUM];
    logic [REG_NUM-1:0]      has_dep;
    logic                    commit_valid;
    logic                    rename_valid;

    assign commit_valid = rdy_in && !clear && is_live_reg(set_reg_id);
    assign rename_valid = rdy_in && !clear && is_live_reg(set_dep_reg_id);

    // Rename is applied after commit so it wins on the dependency fields.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= '0;
                dep[i]  <= '0;
            end
            has_dep <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < int'(REG_NUM); i++) begin
                    dep[i] <= '0;
                end
                has_dep <= '0;
            end else begin
                if (commit_valid) begin
                    regs[set_reg_id] <= set_val;
                    if (has_dep[set_reg_id] && dep[set_reg_id] == set_reg_on_rob_id) begin
                        has_dep[set_reg_id] <= 1'b0;
                    end
                end
                if (rename_valid) begin
                    has_dep[set_dep_reg_id] <= 1'b1;
                    dep[set_dep_reg_id]     <= set_dep_rob_id;
                end
            end
        end
    end

    assign get_rob_id1 = dep[get_reg_1];
    assign get_rob_id2 = dep[get_reg_2];

    reg_operand_resolve #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_resolve_1 (
        .reg_id        (get_reg_1),
        .reg_val       (regs[get_reg_1]),
        .has_dep       (has_dep[get_reg_1]),
        .dep           (dep[get_reg_1]),
        .commit_valid  (commit_valid),
        .commit_reg_id (set_reg_id),
        .commit_rob_id (set_reg_on_rob_id),
        .commit_val    (set_val),
        .rob_ready     (rob_value1_ready),
        .rob_value     (rob_value1),
        .val           (get_val_1),
        .pending       (get_has_dep_1),
        .pending_dep   (get_dep_1)
    );

    reg_operand_resolve #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_resolve_2 (
        .reg_id        (get_reg_2),
        .reg_val       (regs[get_reg_2]),
        .has_dep       (has_dep[get_reg_2]),
        .dep           (dep[get_reg_2]),
        .commit_valid  (commit_valid),
        .commit_reg_id (set_reg_id),
        .commit_rob_id (set_reg_on_rob_id),
        .commit_val    (set_val),
        .rob_ready     (rob_value2_ready),
        .rob_value     (rob_value2),
        .val           (get_val_2),
        .pending       (get_has_dep_2),
        .pending_dep   (get_dep_2)
    );
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with a queue of expected operand results.
module tb_register_file;
    localparam int unsigned RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear;
    logic [4:0]    set_reg_id;
    logic [31:0]   set_val;
    logic [RB-1:0] set_reg_on_rob_id;
    logic [4:0]    set_dep_reg_id;
    logic [RB-1:0] set_dep_rob_id;
    logic [4:0]    get_reg_1, get_reg_2;
    logic [31:0]   get_val_1, get_val_2;
    logic          get_has_dep_1, get_has_dep_2;
    logic [RB-1:0] get_dep_1, get_dep_2;
    logic [RB-1:0] get_rob_id1, get_rob_id2;
    logic          rob_value1_ready, rob_value2_ready;
    logic [31:0]   rob_value1, rob_value2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] val;
        logic        hd;
        logic [31:0] dep;
    } exp_t;
    exp_t sb[$];

    always #5 clk_in = ~clk_in;

    register_file #(.ROB_SIZE_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
        .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
        .get_reg_1(get_reg_1), .get_reg_2(get_reg_2),
        .get_val_1(get_val_1), .get_val_2(get_val_2),
        .get_has_dep_1(get_has_dep_1), .get_has_dep_2(get_has_dep_2),
        .get_dep_1(get_dep_1), .get_dep_2(get_dep_2),
        .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
        .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2)
    );

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int port, input logic [31:0] val,
                        input logic hd, input logic [31:0] dep);
        exp_t e;
        e.tag = tag; e.port = port; e.val = val; e.hd = hd; e.dep = dep;
        sb.push_back(e);
    endtask

    // Let the combinational lookup settle, then retire every queued expectation.
    task automatic check_all();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == 1) begin
                cmp({e.tag, ".val"}, get_val_1, e.val);
                cmp({e.tag, ".has_dep"}, 32'(get_has_dep_1), 32'(e.hd));
                cmp({e.tag, ".dep"}, 32'(get_dep_1), e.dep);
            end else begin
                cmp({e.tag, ".val"}, get_val_2, e.val);
                cmp({e.tag, ".has_dep"}, 32'(get_has_dep_2), 32'(e.hd));
                cmp({e.tag, ".dep"}, 32'(get_dep_2), e.dep);
            end
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; clear = 1'b0;
        set_reg_id = '0; set_val = '0; set_reg_on_rob_id = '0;
        set_dep_reg_id = '0; set_dep_rob_id = '0;
        rob_value1_ready = 1'b0; rob_value1 = '0;
        rob_value2_ready = 1'b0; rob_value2 = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] r, input logic [RB-1:0] tag);
        set_dep_reg_id = r; set_dep_rob_id = tag;
        tick();
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] v, input logic [RB-1:0] tag);
        set_reg_id = r; set_val = v; set_reg_on_rob_id = tag;
        tick();
    endtask

    initial begin
        idle();
        get_reg_1 = 5'd5; get_reg_2 = 5'd0;
        rst_in = 1'b0;
        push("reset_x5", 1, 32'h0, 1'b0, 32'h0);
        check_all();
        cmp("reset_rob_id1", 32'(get_rob_id1), 32'h0);
        @(negedge clk_in); rst_in = 1'b1;
        tick();
        push("post_reset_x5", 1, 32'h0, 1'b0, 32'h0);
        check_all();

        // Rename x3 -> tag 2, then look it up with and without ROB forwarding.
        rename(5'd3, 4'd2);
        get_reg_1 = 5'd3;
        push("x3_pending", 1, 32'h0, 1'b1, 32'h2);
        check_all();
        cmp("x3_rob_id1", 32'(get_rob_id1), 32'h2);
        rob_value1_ready = 1'b1; rob_value1 = 32'h55;
        push("x3_rob_fwd", 1, 32'h55, 1'b0, 32'h0);
        check_all();

        // Matching commit bypasses in the same cycle and clears the dependency.
        set_reg_id = 5'd3; set_val = 32'h1234; set_reg_on_rob_id = 4'd2;
        push("x3_commit_bypass", 1, 32'h1234, 1'b0, 32'h0);
        check_all();
        tick();
        push("x3_committed", 1, 32'h1234, 1'b0, 32'h0);
        check_all();

        // Stale commit writes the value but keeps the newer owner.
        rename(5'd3, 4'd2);
        rename(5'd3, 4'd5);
        set_reg_id = 5'd3; set_val = 32'hAA; set_reg_on_rob_id = 4'd2;
        push("x3_stale_same_cycle", 1, 32'h0, 1'b1, 32'h5);
        check_all();
        tick();
        push("x3_stale_after", 1, 32'h0, 1'b1, 32'h5);
        check_all();
        clear = 1'b1;
        tick();
        push("x3_stale_value", 1, 32'hAA, 1'b0, 32'h0);
        check_all();

        // Commit and rename to the same register in one cycle: rename wins.
        rename(5'd3, 4'd2);
        get_reg_2 = 5'd3;
        set_reg_id = 5'd3; set_val = 32'h77; set_reg_on_rob_id = 4'd2;
        set_dep_reg_id = 5'd3; set_dep_rob_id = 4'd6;
        push("x3_port2_bypass", 2, 32'h77, 1'b0, 32'h0);
        check_all();
        tick();
        push("x3_rename_wins", 2, 32'h0, 1'b1, 32'h6);
        check_all();
        rob_value2_ready = 1'b1; rob_value2 = 32'h99;
        push("x3_port2_fwd", 2, 32'h99, 1'b0, 32'h0);
        check_all();

        // Register 0 ignores both commit and rename.
        set_reg_id = 5'd0; set_val = 32'hFF; set_reg_on_rob_id = 4'd4;
        set_dep_reg_id = 5'd0; set_dep_rob_id = 4'd4;
        tick();
        get_reg_1 = 5'd0; get_reg_2 = 5'd0;
        push("x0_port1", 1, 32'h0, 1'b0, 32'h0);
        push("x0_port2", 2, 32'h0, 1'b0, 32'h0);
        check_all();
        cmp("x0_rob_id1", 32'(get_rob_id1), 32'h0);

        // Clear drops all dependencies but keeps values.
        commit(5'd1, 32'h11, 4'd0);
        commit(5'd7, 32'h71, 4'd0);
        rename(5'd1, 4'd1);
        rename(5'd7, 4'd7);
        get_reg_1 = 5'd1; get_reg_2 = 5'd7;
        push("x1_dep", 1, 32'h0, 1'b1, 32'h1);
        push("x7_dep", 2, 32'h0, 1'b1, 32'h7);
        check_all();
        clear = 1'b1;
        tick();
        push("x1_cleared", 1, 32'h11, 1'b0, 32'h0);
        push("x7_cleared", 2, 32'h71, 1'b0, 32'h0);
        check_all();
        get_reg_2 = 5'd3;
        push("x3_cleared", 2, 32'h77, 1'b0, 32'h0);
        check_all();

        // Stall freezes state, even against rename and clear.
        rdy_in = 1'b0; set_dep_reg_id = 5'd1; set_dep_rob_id = 4'd3;
        tick();
        push("x1_stall_rename", 1, 32'h11, 1'b0, 32'h0);
        check_all();
        rename(5'd7, 4'd2);
        rdy_in = 1'b0; clear = 1'b1;
        tick();
        get_reg_2 = 5'd7;
        push("x7_stall_clear", 2, 32'h0, 1'b1, 32'h2);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
